// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the 32x32 fast multiplier.
// The control FSM and the arithmetic unit both use these.
package mult32x32_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P00  = 3'd1,
        P10  = 3'd2,
        P01  = 3'd3,
        P11  = 3'd4,
        DONE = 3'd5
    } mult_state_t;

    localparam logic [1:0] SHIFT_0  = 2'b00;
    localparam logic [1:0] SHIFT_16 = 2'b01;
    localparam logic [1:0] SHIFT_32 = 2'b10;
    localparam logic       SEL_LSW  = 1'b0;
    localparam logic       SEL_MSW  = 1'b1;

endpackage : mult32x32_pkg

// File: rtl/mult32x32_fast_ctrl_if.sv
// Handshake and datapath-control bundle between the multiplier controller
// and its surroundings (system start/busy/done plus arith unit steering).
interface mult32x32_fast_ctrl_if;

    logic       start;
    logic       a_msw_is_0;
    logic       b_msw_is_0;
    logic       busy;
    logic       done;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] shift_sel;
    logic       upd_prod;
    logic       clr_prod;

    modport master (
        input  start, a_msw_is_0, b_msw_is_0,
        output busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
    );

    modport slave (
        output start, a_msw_is_0, b_msw_is_0,
        input  busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
    );

endinterface : mult32x32_fast_ctrl_if

// File: rtl/mult32x32_fast_ctrl.sv
// Sequencing FSM for the 32x32 fast multiplier: steps through the 16x16
// partial products, skipping those whose operand MSW is zero.
module mult32x32_fast_ctrl
    import mult32x32_pkg::*;
#(
    parameter bit SKIP_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mult32x32_fast_ctrl_if.master ctrl_if
);

    mult_state_t state_q;
    mult_state_t state_d;
    logic        a0;
    logic        b0;

    assign a0 = SKIP_EN && ctrl_if.a_msw_is_0;
    assign b0 = SKIP_EN && ctrl_if.b_msw_is_0;

    // NOTE: only the state register is reset; all outputs decode from it,
    // so an asynchronous reset clears every control in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned
        // (which would infer a latch); it also sends illegal codes to IDLE.
        state_d = IDLE;
        unique case (state_q)
            IDLE: state_d = ctrl_if.start ? P00 : IDLE;
            P00: begin
                if (!a0)      state_d = P10;
                else if (!b0) state_d = P01;
                else          state_d = DONE;
            end
            P10:  state_d = !b0 ? P01 : DONE;
            P01:  state_d = !a0 ? P11 : DONE;
            P11:  state_d = DONE;
            DONE: state_d = ctrl_if.start ? P00 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_if.busy      = 1'b0;
        ctrl_if.done      = 1'b0;
        ctrl_if.a_sel     = SEL_LSW;
        ctrl_if.b_sel     = SEL_LSW;
        ctrl_if.shift_sel = SHIFT_0;
        ctrl_if.upd_prod  = 1'b0;
        ctrl_if.clr_prod  = 1'b0;
        unique case (state_q)
            P00: begin
                ctrl_if.busy     = 1'b1;
                ctrl_if.clr_prod = 1'b1;
            end
            P10: begin
                ctrl_if.busy      = 1'b1;
                ctrl_if.a_sel     = SEL_MSW;
                ctrl_if.shift_sel = SHIFT_16;
                ctrl_if.upd_prod  = 1'b1;
            end
            P01: begin
                ctrl_if.busy      = 1'b1;
                ctrl_if.b_sel     = SEL_MSW;
                ctrl_if.shift_sel = SHIFT_16;
                ctrl_if.upd_prod  = 1'b1;
            end
            P11: begin
                ctrl_if.busy      = 1'b1;
                ctrl_if.a_sel     = SEL_MSW;
                ctrl_if.b_sel     = SEL_MSW;
                ctrl_if.shift_sel = SHIFT_32;
                ctrl_if.upd_prod  = 1'b1;
            end
            DONE: ctrl_if.done = 1'b1;
            default: ;
        endcase
    end

endmodule : mult32x32_fast_ctrl
